id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width; RIDX, default 5, register-index width; CNTW, default 16, bubble-counter width.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_valid  in  1  ID holds a real instruction.
REQ-005 SHALL have ports: id_ctrl  in  ctrl_t  decoder bundle: AluSrc[1:0], AluOp[3:0], PCSrc, MemRead, MemWrite, RbSelect, MemToReg[1:0], RegWrite.
REQ-006 SHALL have ports: id_pc, id_ra_data, id_rb_data, id_imm  in  XLEN each  PC, operands, sign-extended immediate.
REQ-007 SHALL have ports: id_ra, id_rb, id_rd  in  RIDX each  source and destination indices.
REQ-008 SHALL have ports: flush  in  1  kill the ID instruction (redirect).
REQ-009 SHALL have ports: ex_hold  in  1  EX busy (multi-cycle MUL); freeze this register.
REQ-010 SHALL have ports: ex_valid, ex_ctrl, ex_pc, ex_ra_data, ex_rb_data, ex_imm, ex_ra, ex_rb, ex_rd  out  registered copies.
REQ-011 SHALL have ports: id_stall  out  1  hold PC and IF/ID register this cycle.
REQ-012 SHALL have ports: bubble_count  out  CNTW  number of bubbles inserted since reset.

Function
REQ-013 SHALL compute rb_used = (id_ctrl.AluSrc == 2'b00) | id_ctrl.MemWrite.
REQ-014 SHALL compute load_use = id_valid & ex_valid & ex_ctrl.MemRead & ex_ctrl.RegWrite & (ex_rd != 0) & ((ex_rd == id_ra) | (rb_used & ex_rd == id_rb)), combinationally.
REQ-015 SHALL drive id_stall = ex_hold | (load_use & ~flush), combinationally, same cycle.
REQ-016 SHALL update the register each edge by priority: reset > ex_hold > flush > load_use > load.
- ex_hold: all ex_* keep their value.
- flush or load_use: bubble.
- load: all ex_* <= id_* and ex_valid <= id_valid.
REQ-017 SHALL define a bubble as ex_valid=0, ex_ctrl all-zero (NOP encoding), all data and index outputs zero.
REQ-018 SHALL ensure that an invalid ID slot (id_valid=0) loaded normally also yields ex_ctrl all-zero, so no side effect reaches EX.
REQ-019 SHALL give latency exactly 1 cycle ID to EX when no hold, flush or hazard is present.
REQ-020 SHALL hold the load_use bubble for exactly one cycle: the next cycle, ex_* is a bubble, load_use re-evaluates false, and the stalled instruction loads.
REQ-021 SHALL give flush priority over load_use when both are high: bubble, and id_stall low.
REQ-022 SHALL ignore flush while ex_hold is high (no register change); the flush source keeps flush asserted until hold drops.
REQ-023 SHALL increment bubble_count on each edge where a bubble is written due to flush or load_use, saturating at all-ones; no increment under ex_hold or reset.
REQ-024 SHALL treat writes with ex_rd=0 as never hazardous (r0 hard-wired).

Reset
REQ-025 SHALL clear all ex_* outputs, ex_valid and bubble_count to zero on the first edge with reset=1, including mid-stall or mid-hold.
REQ-026 SHALL apply reset over ex_hold and flush; id_stall stays combinational and follows REQ-015 from the cleared state.

Structure
REQ-027 SHALL place ctrl_t (packed struct of decoder outputs), opcode constants (ADD, MUL, ADDI, SW, LW, JAL) and CTRL_NOP in shared package rinsc_pkg.
REQ-028 SHALL implement load_use in one sub-module, hazard_detect (purely combinational); id_ex_stage holds all state.

Verification
REQ-029 SHALL cover straight-line operation: ADD (ctrl.RegWrite=1, rd=3) then ADDI with no hazard -> ex_* equal ID values one cycle later; id_stall=0; bubble_count=0.
REQ-030 SHALL cover load-use: LW rd=5 in EX, ADD ra=5 in ID -> id_stall=1 for one cycle, ex_valid=0 next cycle, ADD in EX the cycle after; bubble_count=1.
REQ-031 SHALL cover the r0 and non-use cases: LW rd=0 with ADD ra=0 -> no stall; LW rd=7 with ADDI rb=7 (rb unused) -> no stall.
REQ-032 SHALL cover flush with hazard: flush=1 and load_use=1 together -> id_stall=0, bubble written, bubble_count +1; also, JAL in EX followed by flush -> next ex_ctrl all-zero.
REQ-033 SHALL cover hold: ex_hold=1 for 3 cycles with flush pulsed during the hold -> ex_* unchanged for all 3 cycles, id_stall=1, bubble_count unchanged.
REQ-034 SHALL cover reset and saturation: reset asserted during a load-use stall -> all outputs 0 next edge; 2^CNTW+2 flushes -> bubble_count = all-ones.

Source files
------------

// File: rtl/rinsc_pkg.sv
// Shared decoder types and constants for the rinsc pipeline.
// ctrl_t is the decoder output bundle carried from ID into EX.
package rinsc_pkg;

    typedef struct packed {
        logic [1:0] AluSrc;
        logic [3:0] AluOp;
        logic       PCSrc;
        logic       MemRead;
        logic       MemWrite;
        logic       RbSelect;
        logic [1:0] MemToReg;
        logic       RegWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [5:0] ADD  = 6'h00;
    localparam logic [5:0] MUL  = 6'h01;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] SW   = 6'h10;
    localparam logic [5:0] LW   = 6'h11;
    localparam logic [5:0] JAL  = 6'h18;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_MUL = 4'd2;

    // AluSrc: 00 = rb, 01 = imm, 10 = pc.  MemToReg: 00 = alu, 01 = mem, 10 = pc+4.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            ADD:  begin c.AluOp = ALU_ADD; c.RegWrite = 1'b1; end
            MUL:  begin c.AluOp = ALU_MUL; c.RegWrite = 1'b1; end
            ADDI: begin c.AluSrc = 2'b01; c.AluOp = ALU_ADD; c.RegWrite = 1'b1; end
            LW: begin
                c.AluSrc   = 2'b01;
                c.MemRead  = 1'b1;
                c.MemToReg = 2'b01;
                c.RegWrite = 1'b1;
            end
            SW: begin
                c.AluSrc   = 2'b01;
                c.MemWrite = 1'b1;
                c.RbSelect = 1'b1;
            end
            JAL: begin
                c.AluSrc   = 2'b10;
                c.PCSrc    = 1'b1;
                c.MemToReg = 2'b10;
                c.RegWrite = 1'b1;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the ID
// instruction forces a one-cycle bubble.
module hazard_detect
    import rinsc_pkg::*;
#(
    parameter int unsigned RIDX = 5
) (
    input  logic            id_valid,
    input  ctrl_t           id_ctrl,
    input  logic [RIDX-1:0] id_ra,
    input  logic [RIDX-1:0] id_rb,
    input  logic            ex_valid,
    input  ctrl_t           ex_ctrl,
    input  logic [RIDX-1:0] ex_rd,
    output logic            load_use
);

    logic rb_used;
    logic ra_match;
    logic rb_match;

    always_comb begin
        rb_used  = (id_ctrl.AluSrc == 2'b00) | id_ctrl.MemWrite;
        ra_match = (ex_rd == id_ra);
        rb_match = rb_used & (ex_rd == id_rb);
        // r0 is hard-wired, so a load targeting it never creates a dependency
        load_use = id_valid & ex_valid & ex_ctrl.MemRead & ex_ctrl.RegWrite
                 & (ex_rd != '0) & (ra_match | rb_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold, flush and load-use bubble insertion,
// plus a saturating count of inserted bubbles.
module id_ex_stage
    import rinsc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RIDX = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  ctrl_t           id_ctrl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_ra_data,
    input  logic [XLEN-1:0] id_rb_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RIDX-1:0] id_ra,
    input  logic [RIDX-1:0] id_rb,
    input  logic [RIDX-1:0] id_rd,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            ex_valid,
    output ctrl_t           ex_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_ra_data,
    output logic [XLEN-1:0] ex_rb_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RIDX-1:0] ex_ra,
    output logic [RIDX-1:0] ex_rb,
    output logic [RIDX-1:0] ex_rd,
    output logic            id_stall,
    output logic [CNTW-1:0] bubble_count
);

    logic load_use;

    hazard_detect #(
        .RIDX(RIDX)
    ) u_hazard_detect (
        .id_valid(id_valid),
        .id_ctrl (id_ctrl),
        .id_ra   (id_ra),
        .id_rb   (id_rb),
        .ex_valid(ex_valid),
        .ex_ctrl (ex_ctrl),
        .ex_rd   (ex_rd),
        .load_use(load_use)
    );

    // A flush discards the ID instruction anyway, so there is nothing to hold
    assign id_stall = ex_hold | (load_use & ~flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= CTRL_NOP;
            ex_pc        <= '0;
            ex_ra_data   <= '0;
            ex_rb_data   <= '0;
            ex_imm       <= '0;
            ex_ra        <= '0;
            ex_rb        <= '0;
            ex_rd        <= '0;
            bubble_count <= '0;
        end else if (ex_hold) begin
            ex_valid <= ex_valid;
        end else if (flush | load_use) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_NOP;
            ex_pc      <= '0;
            ex_ra_data <= '0;
            ex_rb_data <= '0;
            ex_imm     <= '0;
            ex_ra      <= '0;
            ex_rb      <= '0;
            ex_rd      <= '0;
            if (bubble_count != {CNTW{1'b1}}) begin
                bubble_count <= bubble_count + CNTW'(1);
            end
        end else begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_valid ? id_ctrl : CTRL_NOP;
            ex_pc      <= id_pc;
            ex_ra_data <= id_ra_data;
            ex_rb_data <= id_rb_data;
            ex_imm     <= id_imm;
            ex_ra      <= id_ra;
            ex_rb      <= id_rb;
            ex_rd      <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage, plus a bubble-counter saturation run.
module tb_id_ex_stage;
    import rinsc_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned CNTW = 4;
    localparam int unsigned NVEC = 25;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    ctrl_t           id_ctrl;
    logic [XLEN-1:0] id_pc, id_ra_data, id_rb_data, id_imm;
    logic [RIDX-1:0] id_ra, id_rb, id_rd;
    logic            flush, ex_hold;
    logic            ex_valid;
    ctrl_t           ex_ctrl;
    logic [XLEN-1:0] ex_pc, ex_ra_data, ex_rb_data, ex_imm;
    logic [RIDX-1:0] ex_ra, ex_rb, ex_rd;
    logic            id_stall;
    logic [CNTW-1:0] bubble_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .XLEN(XLEN),
        .RIDX(RIDX),
        .CNTW(CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .id_pc       (id_pc),
        .id_ra_data  (id_ra_data),
        .id_rb_data  (id_rb_data),
        .id_imm      (id_imm),
        .id_ra       (id_ra),
        .id_rb       (id_rb),
        .id_rd       (id_rd),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .ex_valid    (ex_valid),
        .ex_ctrl     (ex_ctrl),
        .ex_pc       (ex_pc),
        .ex_ra_data  (ex_ra_data),
        .ex_rb_data  (ex_rb_data),
        .ex_imm      (ex_imm),
        .ex_ra       (ex_ra),
        .ex_rb       (ex_rb),
        .ex_rd       (ex_rd),
        .id_stall    (id_stall),
        .bubble_count(bubble_count)
    );

    typedef struct {
        logic            v;
        ctrl_t           c;
        logic [XLEN-1:0] pc;
        logic [RIDX-1:0] ra, rb, rd;
        logic            fl, hold, rst;
        logic            e_stall;
        logic            e_v;
        ctrl_t           e_c;
        logic [XLEN-1:0] e_pc;
        logic [RIDX-1:0] e_ra, e_rb, e_rd;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    ctrl_t c_add, c_mul, c_addi, c_lw, c_sw, c_jal, c_nop;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t row(input logic v, input ctrl_t c, input logic [XLEN-1:0] pc,
                                 input int ra, input int rb, input int rd,
                                 input logic fl, input logic hold, input logic rst,
                                 input logic e_stall, input logic e_v, input ctrl_t e_c,
                                 input logic [XLEN-1:0] e_pc, input int e_ra, input int e_rb,
                                 input int e_rd, input int e_cnt);
        vec_t r;
        r.v = v; r.c = c; r.pc = pc;
        r.ra = RIDX'(ra); r.rb = RIDX'(rb); r.rd = RIDX'(rd);
        r.fl = fl; r.hold = hold; r.rst = rst;
        r.e_stall = e_stall; r.e_v = e_v; r.e_c = e_c; r.e_pc = e_pc;
        r.e_ra = RIDX'(e_ra); r.e_rb = RIDX'(e_rb); r.e_rd = RIDX'(e_rd);
        r.e_cnt = CNTW'(e_cnt);
        return r;
    endfunction

    // Operand data is derived from pc so expected EX data follows from the expected pc
    task automatic drive(input logic v, input ctrl_t c, input logic [XLEN-1:0] pc,
                         input logic [RIDX-1:0] ra, input logic [RIDX-1:0] rb,
                         input logic [RIDX-1:0] rd, input logic fl, input logic hold,
                         input logic rst);
        id_valid = v; id_ctrl = c; id_pc = pc;
        id_ra_data = pc + 1; id_rb_data = pc + 2; id_imm = pc + 3;
        id_ra = ra; id_rb = rb; id_rd = rd;
        flush = fl; ex_hold = hold; reset = rst;
    endtask

    task automatic check_ex(input int idx, input logic e_v, input ctrl_t e_c,
                            input logic [XLEN-1:0] e_pc, input logic [RIDX-1:0] e_ra,
                            input logic [RIDX-1:0] e_rb, input logic [RIDX-1:0] e_rd,
                            input logic [CNTW-1:0] e_cnt);
        logic [XLEN-1:0] base;
        base = e_pc;
        chk("ex_valid", idx, 32'(ex_valid), 32'(e_v));
        chk("ex_ctrl", idx, 32'(ex_ctrl), 32'(e_c));
        chk("ex_pc", idx, ex_pc, e_pc);
        chk("ex_ra_data", idx, ex_ra_data, (base == 0) ? 32'h0 : base + 1);
        chk("ex_rb_data", idx, ex_rb_data, (base == 0) ? 32'h0 : base + 2);
        chk("ex_imm", idx, ex_imm, (base == 0) ? 32'h0 : base + 3);
        chk("ex_ra", idx, 32'(ex_ra), 32'(e_ra));
        chk("ex_rb", idx, 32'(ex_rb), 32'(e_rb));
        chk("ex_rd", idx, 32'(ex_rd), 32'(e_rd));
        chk("bubble_count", idx, 32'(bubble_count), 32'(e_cnt));
    endtask

    initial begin
        c_nop  = '0;
        c_add  = '0; c_add.RegWrite = 1'b1;
        c_mul  = '0; c_mul.AluOp = 4'd2; c_mul.RegWrite = 1'b1;
        c_addi = '0; c_addi.AluSrc = 2'b01; c_addi.RegWrite = 1'b1;
        c_lw   = '0; c_lw.AluSrc = 2'b01; c_lw.MemRead = 1'b1; c_lw.MemToReg = 2'b01;
        c_lw.RegWrite = 1'b1;
        c_sw   = '0; c_sw.AluSrc = 2'b01; c_sw.MemWrite = 1'b1; c_sw.RbSelect = 1'b1;
        c_jal  = '0; c_jal.AluSrc = 2'b10; c_jal.PCSrc = 1'b1; c_jal.MemToReg = 2'b10;
        c_jal.RegWrite = 1'b1;

        //             v  ctrl    pc       ra rb rd fl hld rst stl ev ectrl   epc      era erb erd cnt
        vecs[0]  = row(1, c_add,  'h100,  1, 2, 3, 0, 0, 0,  0, 1, c_add,  'h100,  1, 2, 3, 0);
        vecs[1]  = row(1, c_addi, 'h104,  3, 0, 4, 0, 0, 0,  0, 1, c_addi, 'h104,  3, 0, 4, 0);
        vecs[2]  = row(1, c_lw,   'h108,  1, 0, 5, 0, 0, 0,  0, 1, c_lw,   'h108,  1, 0, 5, 0);
        vecs[3]  = row(1, c_add,  'h10C,  5, 6, 7, 0, 0, 0,  1, 0, c_nop,  'h0,    0, 0, 0, 1);
        vecs[4]  = row(1, c_add,  'h10C,  5, 6, 7, 0, 0, 0,  0, 1, c_add,  'h10C,  5, 6, 7, 1);
        vecs[5]  = row(1, c_lw,   'h110,  0, 0, 0, 0, 0, 0,  0, 1, c_lw,   'h110,  0, 0, 0, 1);
        vecs[6]  = row(1, c_add,  'h114,  0, 0, 8, 0, 0, 0,  0, 1, c_add,  'h114,  0, 0, 8, 1);
        vecs[7]  = row(1, c_lw,   'h118,  1, 0, 7, 0, 0, 0,  0, 1, c_lw,   'h118,  1, 0, 7, 1);
        vecs[8]  = row(1, c_addi, 'h11C,  2, 7, 9, 0, 0, 0,  0, 1, c_addi, 'h11C,  2, 7, 9, 1);
        vecs[9]  = row(1, c_lw,   'h120,  1, 0, 10, 0, 0, 0, 0, 1, c_lw,   'h120,  1, 0, 10, 1);
        vecs[10] = row(1, c_sw,   'h124,  2, 10, 0, 0, 0, 0, 1, 0, c_nop,  'h0,    0, 0, 0, 2);
        vecs[11] = row(1, c_sw,   'h124,  2, 10, 0, 0, 0, 0, 0, 1, c_sw,   'h124,  2, 10, 0, 2);
        vecs[12] = row(1, c_lw,   'h128,  1, 0, 11, 0, 0, 0, 0, 1, c_lw,   'h128,  1, 0, 11, 2);
        vecs[13] = row(1, c_add,  'h12C, 11, 0, 12, 1, 0, 0, 0, 0, c_nop,  'h0,    0, 0, 0, 3);
        vecs[14] = row(1, c_jal,  'h130,  0, 0, 1, 0, 0, 0,  0, 1, c_jal,  'h130,  0, 0, 1, 3);
        vecs[15] = row(1, c_add,  'h134,  1, 2, 3, 1, 0, 0,  0, 0, c_nop,  'h0,    0, 0, 0, 4);
        vecs[16] = row(0, c_add,  'h138,  1, 2, 3, 0, 0, 0,  0, 0, c_nop,  'h138,  1, 2, 3, 4);
        vecs[17] = row(1, c_add,  'h13C,  1, 2, 3, 0, 0, 0,  0, 1, c_add,  'h13C,  1, 2, 3, 4);
        vecs[18] = row(1, c_mul,  'h140,  3, 4, 5, 0, 1, 0,  1, 1, c_add,  'h13C,  1, 2, 3, 4);
        vecs[19] = row(1, c_mul,  'h140,  3, 4, 5, 1, 1, 0,  1, 1, c_add,  'h13C,  1, 2, 3, 4);
        vecs[20] = row(1, c_mul,  'h140,  3, 4, 5, 0, 1, 0,  1, 1, c_add,  'h13C,  1, 2, 3, 4);
        vecs[21] = row(1, c_mul,  'h140,  3, 4, 5, 0, 0, 0,  0, 1, c_mul,  'h140,  3, 4, 5, 4);
        vecs[22] = row(1, c_lw,   'h144,  1, 0, 6, 0, 0, 0,  0, 1, c_lw,   'h144,  1, 0, 6, 4);
        vecs[23] = row(1, c_add,  'h148,  6, 0, 7, 0, 0, 1,  1, 0, c_nop,  'h0,    0, 0, 0, 0);
        vecs[24] = row(1, c_add,  'h148,  6, 0, 7, 0, 0, 0,  0, 1, c_add,  'h148,  6, 0, 7, 0);

        drive(0, c_nop, 'h0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check_ex(-1, 0, c_nop, 'h0, 0, 0, 0, 0);
        chk("id_stall_reset", -1, 32'(id_stall), 32'h0);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].c, vecs[i].pc, vecs[i].ra, vecs[i].rb, vecs[i].rd,
                  vecs[i].fl, vecs[i].hold, vecs[i].rst);
            #1;
            chk("id_stall", i, 32'(id_stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            check_ex(i, vecs[i].e_v, vecs[i].e_c, vecs[i].e_pc, vecs[i].e_ra, vecs[i].e_rb,
                     vecs[i].e_rd, vecs[i].e_cnt);
        end

        // 2^CNTW + 2 flushes must leave the counter pinned at all-ones
        for (int n = 0; n < (1 << CNTW) + 2; n++) begin
            @(negedge clk);
            drive(1, c_add, 'h200, 1, 2, 3, 1, 0, 0);
            @(posedge clk);
        end
        #1;
        chk("bubble_count_sat", 100, 32'(bubble_count), 32'hF);
        chk("ex_valid_after_flush", 100, 32'(ex_valid), 32'h0);

        @(negedge clk);
        drive(1, c_add, 'h204, 1, 2, 3, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("bubble_count_sat_hold", 101, 32'(bubble_count), 32'hF);
        chk("ex_pc_after_sat", 101, ex_pc, 32'h204);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
